// File: rtl/rvsteel_irq_ctrl.sv
// -----------------------------------------------------------------------------
// rvsteel_irq_ctrl
// Memory-mapped external interrupt controller. Synchronizes NUM_IRQ
// asynchronous sources, latches them as edge- or level-triggered pending bits,
// and provides a claim/complete interface with an internal in-service mask so a
// claimed source cannot re-raise irq until software completes it.
//
// Register map (word index = rw_address[4:2]):
//   0 CR       bit0 EN (global enable of irq output)
//   1 IE       per-source enable mask
//   2 IP       pending bits (edge bits are write-1-to-clear)
//   3 TRIG     1 = edge, 0 = level
//   4 CLAIM    read: claim lowest eligible ID / write: COMPLETE ID
//   5 RAW      synchronized source levels (read-only)
//   6-7        read 0, writes ignored
//
// Ports:
//   clock          single clock, rising edge
//   reset          asynchronous, active-low
//   rw_address     byte address
//   read_data      registered read data
//   read_request   / read_response   read handshake (response one cycle later)
//   write_data, write_strobe, write_request / write_response  write handshake
//   irq_src        asynchronous interrupt sources (bit 0 = machine timer)
//   irq            registered external interrupt request to the core
// -----------------------------------------------------------------------------
module rvsteel_irq_ctrl #(
   parameter int unsigned NUM_IRQ = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [4:0]         rw_address,
   output logic [31:0]        read_data,
   input  logic               read_request,
   output logic               read_response,
   input  logic [31:0]        write_data,
   input  logic [3:0]         write_strobe,
   input  logic               write_request,
   output logic               write_response,
   input  logic [NUM_IRQ-1:0] irq_src,
   output logic               irq
);

   localparam logic [2:0] AddrCr    = 3'd0;
   localparam logic [2:0] AddrIe    = 3'd1;
   localparam logic [2:0] AddrIp    = 3'd2;
   localparam logic [2:0] AddrTrig  = 3'd3;
   localparam logic [2:0] AddrClaim = 3'd4;
   localparam logic [2:0] AddrRaw   = 3'd5;

   logic               en_q;
   logic [NUM_IRQ-1:0] ie_q, ip_q, trig_q, ins_q;
   logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;

   logic [NUM_IRQ-1:0] ip_d, ins_d;
   logic [NUM_IRQ-1:0] cand, claim_mask, claim_take, w1c_mask, complete_mask;
   logic [4:0]         claim_id;
   logic [31:0]        rdata;

   logic [2:0] word;
   logic       aligned, wr_en, rd_en, claim_rd, complete_wr;

   assign word        = rw_address[4:2];
   assign aligned     = (rw_address[1:0] == 2'b00);
   assign wr_en       = write_request && aligned && (write_strobe == 4'hF);
   assign rd_en       = read_request && aligned;
   assign claim_rd    = rd_en && (word == AddrClaim);
   assign complete_wr = wr_en && (word == AddrClaim);

   // Eligible sources; EN gates only the irq output, not claim selection.
   assign cand = ip_q & ie_q & ~ins_q;

   // Lowest-index eligible source wins (scan from the top so the last hit is lowest).
   always_comb begin
      claim_id   = 5'd0;
      claim_mask = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            claim_id      = 5'(i + 1);
            claim_mask    = '0;
            claim_mask[i] = 1'b1;
         end
      end
   end

   // Out-of-range COMPLETE IDs (0 or > NUM_IRQ) match no bit and are ignored.
   always_comb begin
      complete_mask = '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         if (complete_wr && (32'(write_data[4:0]) == 32'(i + 1))) begin
            complete_mask[i] = 1'b1;
         end
      end
   end

   assign claim_take = claim_rd ? claim_mask : '0;
   assign w1c_mask   = (wr_en && (word == AddrIp)) ? write_data[NUM_IRQ-1:0] : '0;

   // Edge bits: a new edge wins over a same-cycle W1C or claim clear.
   // Level bits simply follow the synchronized input.
   assign ip_d  = (trig_q & ((s2_q & ~s3_q) | (ip_q & ~(w1c_mask | claim_take))))
                | (~trig_q & s2_q);
   assign ins_d = (ins_q & ~complete_mask) | claim_take;

   always_comb begin
      rdata = 32'd0;
      case (word)
         AddrCr:    rdata = {31'd0, en_q};
         AddrIe:    rdata = 32'(ie_q);
         AddrIp:    rdata = 32'(ip_q);
         AddrTrig:  rdata = 32'(trig_q);
         AddrClaim: rdata = 32'(claim_id);
         AddrRaw:   rdata = 32'(s2_q);
         default:   rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= irq_src;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         en_q   <= 1'b0;
         ie_q   <= '0;
         trig_q <= '0;
      end else if (wr_en) begin
         case (word)
            AddrCr:   en_q   <= write_data[0];
            AddrIe:   ie_q   <= write_data[NUM_IRQ-1:0];
            AddrTrig: trig_q <= write_data[NUM_IRQ-1:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ip_q  <= '0;
         ins_q <= '0;
         irq   <= 1'b0;
      end else begin
         ip_q  <= ip_d;
         ins_q <= ins_d;
         irq   <= en_q && (|cand);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         read_data      <= 32'd0;
         read_response  <= 1'b0;
         write_response <= 1'b0;
      end else begin
         read_response  <= read_request;
         write_response <= write_request;
         if (rd_en) begin
            read_data <= rdata;
         end
      end
   end

endmodule

// File: tb/tb_rvsteel_irq_ctrl.sv
module tb_rvsteel_irq_ctrl;

   localparam int unsigned N = 16;

   localparam logic [4:0] ACr    = 5'h00;
   localparam logic [4:0] AIe    = 5'h04;
   localparam logic [4:0] AIp    = 5'h08;
   localparam logic [4:0] ATrig  = 5'h0C;
   localparam logic [4:0] AClaim = 5'h10;
   localparam logic [4:0] ARaw   = 5'h14;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [4:0]    rw_address = '0;
   logic [31:0]   read_data;
   logic          read_request = 1'b0;
   logic          read_response;
   logic [31:0]   write_data = '0;
   logic [3:0]    write_strobe = '0;
   logic          write_request = 1'b0;
   logic          write_response;
   logic [N-1:0]  irq_src = '0;
   logic          irq;

   int unsigned total  = 0;
   int unsigned passed = 0;

   rvsteel_irq_ctrl #(.NUM_IRQ(N)) dut (
      .clock          (clock),
      .reset          (reset),
      .rw_address     (rw_address),
      .read_data      (read_data),
      .read_request   (read_request),
      .read_response  (read_response),
      .write_data     (write_data),
      .write_strobe   (write_strobe),
      .write_request  (write_request),
      .write_response (write_response),
      .irq_src        (irq_src),
      .irq            (irq)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_read(input logic [4:0] addr, output logic [31:0] data);
      rw_address   = addr;
      read_request = 1'b1;
      tick(1);
      read_request = 1'b0;
      check("read_response", 32'(read_response), 32'd1);
      data = read_data;
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      rw_address    = addr;
      write_data    = data;
      write_strobe  = strb;
      write_request = 1'b1;
      tick(1);
      write_request = 1'b0;
      check("write_response", 32'(write_response), 32'd1);
   endtask

   task automatic apply_reset();
      reset         = 1'b0;
      irq_src       = '0;
      read_request  = 1'b0;
      write_request = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);
   endtask

   function automatic logic [4:0] lowest_id(input logic [N-1:0] m);
      for (int i = 0; i < int'(N); i++) if (m[i]) return 5'(i + 1);
      return 5'd0;
   endfunction

   function automatic vec_t vw(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      vec_t v;
      v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.exp = '0;
      return v;
   endfunction

   function automatic vec_t vr(input logic [4:0] a, input logic [31:0] e);
      vec_t v;
      v.wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.exp = e;
      return v;
   endfunction

   initial begin
      vec_t        tbl[$];
      logic [31:0] rd;
      logic [N-1:0] trig, ie, lvl, pulse, pend, ins, m;
      logic        en;
      int          c;

      tbl.push_back(vw(AIe, 32'hFFFF_FFFF, 4'hF));
      tbl.push_back(vr(AIe, 32'h0000_FFFF));
      tbl.push_back(vw(AIe, 32'hAAAA_AAAA, 4'hF));
      tbl.push_back(vr(AIe, 32'h0000_AAAA));
      tbl.push_back(vw(AIe, 32'h5555_5555, 4'h3));
      tbl.push_back(vr(AIe, 32'h0000_AAAA));
      tbl.push_back(vw(5'h05, 32'h5555_5555, 4'hF));
      tbl.push_back(vr(AIe, 32'h0000_AAAA));
      tbl.push_back(vw(AIe, 32'h5555_5555, 4'hE));
      tbl.push_back(vr(5'h05, 32'h0000_AAAA));      // unaligned read: data holds
      tbl.push_back(vr(AIe, 32'h0000_AAAA));
      tbl.push_back(vw(ATrig, 32'hFFFF_0F0F, 4'hF));
      tbl.push_back(vr(ATrig, 32'h0000_0F0F));
      tbl.push_back(vw(ACr, 32'hFFFF_FFFE, 4'hF));
      tbl.push_back(vr(ACr, 32'h0000_0000));
      tbl.push_back(vw(ACr, 32'h0000_0003, 4'hF));
      tbl.push_back(vr(ACr, 32'h0000_0001));
      tbl.push_back(vw(5'h18, 32'hFFFF_FFFF, 4'hF));
      tbl.push_back(vr(5'h18, 32'h0000_0000));
      tbl.push_back(vr(5'h1C, 32'h0000_0000));
      tbl.push_back(vw(ARaw, 32'h0000_FFFF, 4'hF));
      tbl.push_back(vr(ARaw, 32'h0000_0000));
      tbl.push_back(vw(AIp, 32'hFFFF_FFFF, 4'hF));
      tbl.push_back(vr(AIp, 32'h0000_0000));
      tbl.push_back(vr(AClaim, 32'h0000_0000));

      // Asynchronous reset with no clock edge involved.
      #2 reset = 1'b0;
      #1;
      check("rst_read_data", read_data, 32'd0);
      check("rst_read_response", 32'(read_response), 32'd0);
      check("rst_write_response", 32'(write_response), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      tick(1);
      reset = 1'b1;
      tick(1);

      foreach (tbl[k]) begin
         if (tbl[k].wr) begin
            do_write(tbl[k].addr, tbl[k].data, tbl[k].strb);
         end else begin
            do_read(tbl[k].addr, rd);
            check($sformatf("table[%0d]", k), rd, tbl[k].exp);
         end
      end

      // Edge source 0: latency and claim.
      apply_reset();
      do_write(ACr, 32'd1, 4'hF);
      do_write(AIe, 32'd1, 4'hF);
      do_write(ATrig, 32'd1, 4'hF);
      irq_src = 16'h0001;
      tick(1);                       // E1
      irq_src = '0;
      tick(1);                       // E2
      do_read(AIp, rd);              // sampled at E3, before IP updates
      check("lat_ip_e2", rd, 32'd0);
      check("lat_irq_e3", 32'(irq), 32'd0);
      do_read(AIp, rd);              // IP value after E3
      check("lat_ip_e3", rd, 32'd1);
      check("lat_irq_e4", 32'(irq), 32'd1);
      do_read(AClaim, rd);
      check("claim_src0", rd, 32'd1);
      tick(1);
      check("claim_irq_drop", 32'(irq), 32'd0);
      do_read(AIp, rd);
      check("claim_ip_clr", rd, 32'd0);

      // Priority, in-service masking and completion.
      apply_reset();
      do_write(ACr, 32'd1, 4'hF);
      do_write(AIe, 32'h6, 4'hF);
      do_write(ATrig, 32'h7, 4'hF);
      irq_src = 16'h0006;
      tick(1);
      irq_src = '0;
      tick(5);
      check("prio_irq", 32'(irq), 32'd1);
      do_read(AClaim, rd);
      check("prio_claim1", rd, 32'd2);
      tick(1);
      check("prio_irq_still", 32'(irq), 32'd1);
      do_read(AClaim, rd);
      check("prio_claim2", rd, 32'd3);
      tick(1);
      check("prio_irq_low", 32'(irq), 32'd0);
      do_read(AClaim, rd);
      check("prio_claim3", rd, 32'd0);
      irq_src = 16'h0002;
      tick(1);
      irq_src = '0;
      tick(5);
      check("prio_ins_masks", 32'(irq), 32'd0);
      do_write(AClaim, 32'd2, 4'hF);
      tick(2);
      check("prio_complete_irq", 32'(irq), 32'd1);

      // Level source 4.
      apply_reset();
      do_write(ACr, 32'd1, 4'hF);
      do_write(AIe, 32'h10, 4'hF);
      irq_src = 16'h0010;
      tick(5);
      check("lvl_irq", 32'(irq), 32'd1);
      do_read(AClaim, rd);
      check("lvl_claim", rd, 32'd5);
      tick(1);
      check("lvl_irq_drop", 32'(irq), 32'd0);
      do_write(AClaim, 32'd5, 4'hF);
      tick(2);
      check("lvl_irq_again", 32'(irq), 32'd1);
      do_write(AIp, 32'h10, 4'hF);
      do_read(AIp, rd);
      check("lvl_w1c_noeffect", rd, 32'h10);

      // W1C in the same cycle as a new edge: the edge wins.
      apply_reset();
      do_write(ATrig, 32'd1, 4'hF);
      irq_src = 16'h0001;
      tick(1);                       // E1
      irq_src = '0;
      tick(1);                       // E2
      do_write(AIp, 32'd1, 4'hF);    // lands at E3 together with the edge set
      do_read(AIp, rd);
      check("w1c_vs_edge", rd, 32'd1);
      do_write(AIp, 32'd1, 4'hF);
      do_read(AIp, rd);
      check("w1c_clears", rd, 32'd0);

      // Asynchronous reset mid-cycle with irq high and a source in service.
      apply_reset();
      do_write(ACr, 32'd1, 4'hF);
      do_write(AIe, 32'h3, 4'hF);
      irq_src = 16'h0003;
      tick(5);
      do_read(AClaim, rd);
      check("ar_claim", rd, 32'd1);
      tick(1);
      check("ar_irq_pre", 32'(irq), 32'd1);
      rw_address   = AIp;
      read_request = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("ar_irq_now", 32'(irq), 32'd0);
      check("ar_rdata_now", read_data, 32'd0);
      check("ar_resp_now", 32'(read_response), 32'd0);
      tick(1);
      check("ar_resp_held", 32'(read_response), 32'd0);
      read_request = 1'b0;
      irq_src      = '0;
      reset        = 1'b1;
      tick(1);
      check("ar_no_resp", 32'(read_response), 32'd0);
      do_read(ACr, rd);    check("ar_cr", rd, 32'd0);
      do_read(AIe, rd);    check("ar_ie", rd, 32'd0);
      do_read(AIp, rd);    check("ar_ip", rd, 32'd0);
      do_read(ATrig, rd);  check("ar_trig", rd, 32'd0);
      do_read(ARaw, rd);   check("ar_raw", rd, 32'd0);
      do_read(AClaim, rd); check("ar_claim_after", rd, 32'd0);

      // Randomized rounds against a set-based model of pending/in-service.
      for (int r = 0; r < 20; r++) begin
         apply_reset();
         rd = $urandom; en = rd[0];
         do_write(ACr, rd, 4'hF);
         rd = $urandom; ie = rd[N-1:0];
         do_write(AIe, rd, 4'hF);
         rd = $urandom; trig = rd[N-1:0];
         do_write(ATrig, rd, 4'hF);
         lvl   = N'($urandom);
         pulse = N'($urandom);
         irq_src = (lvl & ~trig) | (pulse & trig);
         tick(1);
         irq_src = lvl & ~trig;
         tick(5);
         pend = (lvl & ~trig) | (pulse & trig);
         ins  = '0;
         do_read(AIe, rd);
         check("rnd_ie", rd, 32'(ie));
         do_read(AIp, rd);
         check("rnd_ip", rd, 32'(pend));
         do_read(ARaw, rd);
         check("rnd_raw", rd, 32'(lvl & ~trig));
         check("rnd_irq", 32'(irq), 32'(en && ((pend & ie) != 0)));
         m = N'($urandom);
         do_write(AIp, {16'hFFFF, m}, 4'hF);
         pend = pend & ~(m & trig);
         do_read(AIp, rd);
         check("rnd_ip_w1c", rd, 32'(pend));
         for (int k = 0; k < int'(N) + 1; k++) begin
            logic [4:0] id;
            id = lowest_id(pend & ie & ~ins);
            do_read(AClaim, rd);
            check("rnd_claim", rd, 32'(id));
            if (id != 0) begin
               ins[id-1] = 1'b1;
               if (trig[id-1]) pend[id-1] = 1'b0;
            end
         end
         tick(1);
         check("rnd_irq_claimed", 32'(irq), 32'd0);
         c = $urandom_range(0, 20);
         do_write(AClaim, 32'(c), 4'hF);
         if (c >= 1 && c <= int'(N)) ins[c-1] = 1'b0;
         tick(2);
         check("rnd_irq_complete", 32'(irq), 32'(en && ((pend & ie & ~ins) != 0)));
         do_read(AClaim, rd);
         check("rnd_claim_after", rd, 32'(lowest_id(pend & ie & ~ins)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
